// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer for the 5-stage datapath: RAW interlock (no forwarding), ID-stage
// redirect flush, HI/LO interlock behind multi-cycle mult/madd/msub, and a stall counter.
module pipeline_hazard_ctrl #(
    parameter int MULDIV_CYCLES = 4,
    parameter int WB_BYPASS     = 1,
    parameter int CNT_W         = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [4:0]       id_rs_i,
    input  logic [4:0]       id_rt_i,
    input  logic             id_uses_rs_i,
    input  logic             id_uses_rt_i,
    input  logic             id_redirect_i,
    input  logic             id_hilo_write_i,
    input  logic             id_hilo_read_i,
    input  logic             ex_reg_write_i,
    input  logic [4:0]       ex_write_reg_i,
    input  logic             mem_reg_write_i,
    input  logic [4:0]       mem_write_reg_i,
    input  logic             wb_reg_write_i,
    input  logic [4:0]       wb_write_reg_i,
    output logic             pc_ld_o,
    output logic             if_id_ld_o,
    output logic             if_id_flush_o,
    output logic             id_ex_bubble_o,
    output logic             md_busy_o,
    output logic [CNT_W-1:0] stall_cycles_o
);

    localparam int MD_W = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        STALL   = 2'd1,
        MD_WAIT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [MD_W-1:0]  md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic raw_ex, raw_mem, raw_wb, raw, hilo, stall;

    // $0 is hard-wired, so a write to it can never create a dependency.
    function automatic logic src_match(input logic [4:0] src, input logic uses,
                                       input logic wr_en, input logic [4:0] wr_reg);
        return (src != 5'd0) && uses && wr_en && (wr_reg == src);
    endfunction

    always_comb begin
        raw_ex  = src_match(id_rs_i, id_uses_rs_i, ex_reg_write_i, ex_write_reg_i)
                | src_match(id_rt_i, id_uses_rt_i, ex_reg_write_i, ex_write_reg_i);
        raw_mem = src_match(id_rs_i, id_uses_rs_i, mem_reg_write_i, mem_write_reg_i)
                | src_match(id_rt_i, id_uses_rt_i, mem_reg_write_i, mem_write_reg_i);
        raw_wb  = src_match(id_rs_i, id_uses_rs_i, wb_reg_write_i, wb_write_reg_i)
                | src_match(id_rt_i, id_uses_rt_i, wb_reg_write_i, wb_write_reg_i);
        raw     = raw_ex | raw_mem | ((WB_BYPASS == 0) & raw_wb);
        hilo    = (id_hilo_read_i | id_hilo_write_i) & (md_cnt_q != '0);
        stall   = raw | hilo;
    end

    always_comb begin
        md_cnt_d = md_cnt_q;
        if (id_hilo_write_i && !stall) begin
            md_cnt_d = MD_W'(MULDIV_CYCLES - 1);
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - MD_W'(1);
        end

        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // raw outranks hilo; MD_WAIT holds until the unit drains even if the reader leaves ID.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN, STALL: begin
                if (raw)       state_d = STALL;
                else if (hilo) state_d = MD_WAIT;
                else           state_d = RUN;
            end
            MD_WAIT: begin
                if (raw)                  state_d = STALL;
                else if (md_cnt_d != '0)  state_d = MD_WAIT;
                else                      state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= RUN;
            md_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // A redirect is only trusted once its operands are hazard-free.
    always_comb begin
        pc_ld_o        = 1'b1;
        if_id_ld_o     = 1'b1;
        if_id_flush_o  = 1'b0;
        id_ex_bubble_o = 1'b0;
        if (!rst_ni) begin
            pc_ld_o        = 1'b0;
            if_id_ld_o     = 1'b0;
            if_id_flush_o  = 1'b1;
            id_ex_bubble_o = 1'b1;
        end else if (stall) begin
            pc_ld_o        = 1'b0;
            if_id_ld_o     = 1'b0;
            id_ex_bubble_o = 1'b1;
        end else if (id_redirect_i) begin
            if_id_flush_o  = 1'b1;
        end
    end

    assign md_busy_o      = rst_ni & (md_cnt_q != '0);
    assign stall_cycles_o = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: default instance plus a WB_BYPASS=0 / 4-bit-counter instance on shared stimulus.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs, id_rt, ex_wr, mem_wr, wb_wr;
    logic       uses_rs, uses_rt, redirect, hilo_wr, hilo_rd;
    logic       ex_we, mem_we, wb_we;

    logic        pc_ld, ifid_ld, flush, bubble, busy;
    logic [15:0] scnt;
    logic        pc_ld2, ifid_ld2, flush2, bubble2, busy2;
    logic [3:0]  scnt2;

    int tests = 0;
    int fails = 0;
    int cnt_a, cnt_b;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl dut (
        .clk_i(clk), .rst_ni(rst_n),
        .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rs_i(uses_rs), .id_uses_rt_i(uses_rt),
        .id_redirect_i(redirect), .id_hilo_write_i(hilo_wr), .id_hilo_read_i(hilo_rd),
        .ex_reg_write_i(ex_we), .ex_write_reg_i(ex_wr),
        .mem_reg_write_i(mem_we), .mem_write_reg_i(mem_wr),
        .wb_reg_write_i(wb_we), .wb_write_reg_i(wb_wr),
        .pc_ld_o(pc_ld), .if_id_ld_o(ifid_ld), .if_id_flush_o(flush),
        .id_ex_bubble_o(bubble), .md_busy_o(busy), .stall_cycles_o(scnt)
    );

    pipeline_hazard_ctrl #(.MULDIV_CYCLES(4), .WB_BYPASS(0), .CNT_W(4)) dut2 (
        .clk_i(clk), .rst_ni(rst_n),
        .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rs_i(uses_rs), .id_uses_rt_i(uses_rt),
        .id_redirect_i(redirect), .id_hilo_write_i(hilo_wr), .id_hilo_read_i(hilo_rd),
        .ex_reg_write_i(ex_we), .ex_write_reg_i(ex_wr),
        .mem_reg_write_i(mem_we), .mem_write_reg_i(mem_wr),
        .wb_reg_write_i(wb_we), .wb_write_reg_i(wb_wr),
        .pc_ld_o(pc_ld2), .if_id_ld_o(ifid_ld2), .if_id_flush_o(flush2),
        .id_ex_bubble_o(bubble2), .md_busy_o(busy2), .stall_cycles_o(scnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        id_rs = 5'd0; id_rt = 5'd0; uses_rs = 1'b0; uses_rt = 1'b0;
        redirect = 1'b0; hilo_wr = 1'b0; hilo_rd = 1'b0;
        ex_we = 1'b0; ex_wr = 5'd0; mem_we = 1'b0; mem_wr = 5'd0;
        wb_we = 1'b0; wb_wr = 5'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_ctl(input string tag, input logic p, input logic l,
                           input logic f, input logic b);
        chk({tag, ".pc_ld"}, 32'(pc_ld), 32'(p));
        chk({tag, ".if_id_ld"}, 32'(ifid_ld), 32'(l));
        chk({tag, ".flush"}, 32'(flush), 32'(f));
        chk({tag, ".bubble"}, 32'(bubble), 32'(b));
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        #3;
        chk_ctl("reset", 1'b0, 1'b0, 1'b1, 1'b1);
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.scnt", 32'(scnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_ctl("idle", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();

        // add $1 in EX, beq $1,$2 in ID
        id_rs = 5'd1; id_rt = 5'd2; uses_rs = 1'b1; uses_rt = 1'b1;
        ex_we = 1'b1; ex_wr = 5'd1;
        #1;
        chk_ctl("beq_ex", 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        ex_we = 1'b0; ex_wr = 5'd0; mem_we = 1'b1; mem_wr = 5'd1;
        #1;
        chk_ctl("beq_mem", 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        mem_we = 1'b0; mem_wr = 5'd0; wb_we = 1'b1; wb_wr = 5'd1;
        #1;
        chk("beq_wb.pc_ld", 32'(pc_ld), 32'd1);
        chk("beq_wb.pc_ld_nobyp", 32'(pc_ld2), 32'd0);
        tick();
        idle_inputs();
        #1;
        chk("beq.scnt", 32'(scnt), 32'd2);
        chk("beq.scnt_nobyp", 32'(scnt2), 32'd3);

        // lw $3 then add $4,$3,$5: count stalled cycles as $3 travels EX -> MEM -> WB
        cnt_a = 0; cnt_b = 0;
        for (int k = 0; k < 3; k++) begin
            idle_inputs();
            id_rs = 5'd3; id_rt = 5'd5; uses_rs = 1'b1; uses_rt = 1'b1;
            if (k == 0) begin ex_we = 1'b1; ex_wr = 5'd3; end
            if (k == 1) begin mem_we = 1'b1; mem_wr = 5'd3; end
            if (k == 2) begin wb_we = 1'b1; wb_wr = 5'd3; end
            #1;
            if (!pc_ld) cnt_a++;
            if (!pc_ld2) cnt_b++;
            tick();
        end
        idle_inputs();
        #1;
        chk("lw.stalls_byp", 32'(cnt_a), 32'd2);
        chk("lw.stalls_nobyp", 32'(cnt_b), 32'd3);
        chk("lw.scnt", 32'(scnt), 32'd4);
        chk("lw.scnt_nobyp", 32'(scnt2), 32'd6);

        // $0 writer in every stage never hazards
        id_rs = 5'd0; uses_rs = 1'b1; id_rt = 5'd0; uses_rt = 1'b1;
        ex_we = 1'b1; mem_we = 1'b1; wb_we = 1'b1;
        #1;
        chk_ctl("zero_reg", 1'b1, 1'b1, 1'b0, 1'b0);
        chk("zero_reg.pc_ld_nobyp", 32'(pc_ld2), 32'd1);
        tick();
        idle_inputs();

        // j with no hazard: single flush cycle
        redirect = 1'b1;
        #1;
        chk_ctl("jump", 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        redirect = 1'b0;
        #1;
        chk_ctl("jump_after", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();

        // jr $1 with $1 in EX: flush held off until the hazard clears
        redirect = 1'b1; id_rs = 5'd1; uses_rs = 1'b1; ex_we = 1'b1; ex_wr = 5'd1;
        #1;
        chk_ctl("jr_haz", 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        ex_we = 1'b0; ex_wr = 5'd0;
        #1;
        chk_ctl("jr_clear", 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        idle_inputs();
        #1;
        chk("jr.scnt", 32'(scnt), 32'd5);
        chk("jr.scnt_nobyp", 32'(scnt2), 32'd7);

        // mult issue, mfhi behind it
        hilo_wr = 1'b1;
        #1;
        chk("mult.issue_pc_ld", 32'(pc_ld), 32'd1);
        chk("mult.busy_before", 32'(busy), 32'd0);
        tick();
        hilo_wr = 1'b0; hilo_rd = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("mfhi.busy%0d", k), 32'(busy), 32'd1);
            chk($sformatf("mfhi.pc_ld%0d", k), 32'(pc_ld), 32'd0);
            tick();
        end
        #1;
        chk("mfhi.busy_done", 32'(busy), 32'd0);
        chk_ctl("mfhi.go", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        idle_inputs();
        #1;
        chk("mfhi.scnt", 32'(scnt), 32'd8);

        // mult then mtlo (WAW interlock), then async reset mid-wait
        hilo_wr = 1'b1;
        tick();
        #1;
        chk("waw.busy", 32'(busy), 32'd1);
        chk("waw.pc_ld", 32'(pc_ld), 32'd0);
        hilo_wr = 1'b0; hilo_rd = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst.busy", 32'(busy), 32'd0);
        chk("arst.scnt", 32'(scnt), 32'd0);
        chk("arst.scnt_nobyp", 32'(scnt2), 32'd0);
        chk_ctl("arst", 1'b0, 1'b0, 1'b1, 1'b1);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("arst.busy_after", 32'(busy), 32'd0);
        chk("arst.pc_ld_after", 32'(pc_ld), 32'd1);

        // saturation: 4-bit counter pins at 15, 16-bit keeps counting
        id_rs = 5'd7; uses_rs = 1'b1; ex_we = 1'b1; ex_wr = 5'd7;
        repeat (15) tick();
        chk("sat.scnt_at_max", 32'(scnt2), 32'd15);
        chk("sat.scnt_wide15", 32'(scnt), 32'd15);
        repeat (5) tick();
        chk("sat.scnt_held", 32'(scnt2), 32'd15);
        chk("sat.scnt_wide20", 32'(scnt), 32'd20);
        idle_inputs();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
